// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: write-back select encodings, MEM-stage FSM
// states, the default data-memory timeout, and the MEM/WB register record.
package rv_pipe_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // All-zero value of this record is the pipeline bubble.
  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [1:0]  mem2reg;
    logic        reg_write;
  } memwb_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back select shared by the MEM and WB stages.
// Ports:
//   i_sel  - mem2reg select (WB_ALU / WB_MEM / WB_PC4, 2'b11 gives 0)
//   i_alu  - ALU result
//   i_mem  - load data
//   i_pc4  - return address
//   o_data - selected write-back value
module wb_mux
  import rv_pipe_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_sel)
      WB_ALU:  o_data = i_alu;
      WB_MEM:  o_data = i_mem;
      WB_PC4:  o_data = i_pc4;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the five-stage pipeline: issues word loads/stores to a
// variable-latency data memory over req/ack, stalls upstream while an access
// is outstanding, and drives the MEM/WB register.
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops pass in one cycle
// BUSY  | dmem_req held, waiting for dmem_ack or timeout
//
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   *_EXMEM                - EX/MEM register contents (held stable while stalled)
//   dmem_req/we/addr/wdata - data memory request, latched for the whole access
//   dmem_ack/rdata         - single-cycle completion and load data
//   mem_stall              - freeze upstream stages, bubble into MEM/WB
//   *_MEMWB                - MEM/WB register
//   memData_Out_MEM        - write-back value forwarded to EX
//   misalign_err, bus_err  - one-cycle error pulses
module mem_stage_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_Address_EXMEM,
  input  logic [31:0] write_Data_EXMEM,
  input  logic [31:0] PC_plus4_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  input  logic        memRead_EXMEM,
  input  logic        memWrite_EXMEM,
  input  logic [1:0]  mem2reg_EXMEM,
  input  logic        RegWrite_EXMEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] read_data_MEMWB,
  output logic [31:0] alu_result_MEMWB,
  output logic [31:0] PC_plus4_MEMWB,
  output logic [4:0]  rd_MEMWB,
  output logic [1:0]  mem2reg_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic [31:0] memData_Out_MEM,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  memwb_t           r_memwb;
  logic             r_misalign;
  logic             r_bus_err;

  logic   w_access;
  logic   w_aligned;
  logic   w_cnt_last;
  memwb_t w_cap;

  assign w_access   = memRead_EXMEM | memWrite_EXMEM;
  assign w_aligned  = (read_Address_EXMEM[1:0] == 2'b00);
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  // EX/MEM fields as they land in MEM/WB when no load data is involved.
  always_comb begin
    w_cap            = '0;
    w_cap.alu_result = read_Address_EXMEM;
    w_cap.pc_plus4   = PC_plus4_EXMEM;
    w_cap.rd         = rd_EXMEM;
    w_cap.mem2reg    = mem2reg_EXMEM;
    w_cap.reg_write  = RegWrite_EXMEM;
  end

  // Ack wins over a coinciding timeout.
  assign mem_stall = ((r_state == ST_IDLE) & w_access & w_aligned) |
                     ((r_state == ST_BUSY) & ~dmem_ack & ~w_cnt_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memwb    <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_access && w_aligned) begin
            r_state <= ST_BUSY;
            r_req   <= 1'b1;
            r_we    <= memWrite_EXMEM;
            r_addr  <= read_Address_EXMEM;
            r_wdata <= write_Data_EXMEM;
            r_memwb <= '0;
          end else begin
            // A misaligned access retires without writing the register file.
            r_memwb           <= w_cap;
            r_memwb.reg_write <= RegWrite_EXMEM & ~w_access;
            r_misalign        <= w_access;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_state           <= ST_IDLE;
            r_req             <= 1'b0;
            r_cnt             <= '0;
            r_memwb           <= w_cap;
            r_memwb.read_data <= r_we ? 32'd0 : dmem_rdata;
          end else if (w_cnt_last) begin
            r_state           <= ST_IDLE;
            r_req             <= 1'b0;
            r_cnt             <= '0;
            r_memwb           <= w_cap;
            r_memwb.reg_write <= 1'b0;
            r_bus_err         <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_memwb <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign dmem_req         = r_req;
  assign dmem_we          = r_we;
  assign dmem_addr        = r_addr;
  assign dmem_wdata       = r_wdata;
  assign read_data_MEMWB  = r_memwb.read_data;
  assign alu_result_MEMWB = r_memwb.alu_result;
  assign PC_plus4_MEMWB   = r_memwb.pc_plus4;
  assign rd_MEMWB         = r_memwb.rd;
  assign mem2reg_MEMWB    = r_memwb.mem2reg;
  assign RegWrite_MEMWB   = r_memwb.reg_write;
  assign misalign_err     = r_misalign;
  assign bus_err          = r_bus_err;

  wb_mux u_wb_mux (
    .i_sel  (r_memwb.mem2reg),
    .i_alu  (r_memwb.alu_result),
    .i_mem  (r_memwb.read_data),
    .i_pc4  (r_memwb.pc_plus4),
    .o_data (memData_Out_MEM)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_Address_EXMEM, write_Data_EXMEM, PC_plus4_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic        memRead_EXMEM, memWrite_EXMEM, RegWrite_EXMEM;
  logic [1:0]  mem2reg_EXMEM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall;
  logic [31:0] read_data_MEMWB, alu_result_MEMWB, PC_plus4_MEMWB, memData_Out_MEM;
  logic [4:0]  rd_MEMWB;
  logic [1:0]  mem2reg_MEMWB;
  logic        RegWrite_MEMWB, misalign_err, bus_err;

  int n_chk = 0;
  int n_err = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_Address_EXMEM(read_Address_EXMEM), .write_Data_EXMEM(write_Data_EXMEM),
    .PC_plus4_EXMEM(PC_plus4_EXMEM), .rd_EXMEM(rd_EXMEM),
    .memRead_EXMEM(memRead_EXMEM), .memWrite_EXMEM(memWrite_EXMEM),
    .mem2reg_EXMEM(mem2reg_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .read_data_MEMWB(read_data_MEMWB), .alu_result_MEMWB(alu_result_MEMWB),
    .PC_plus4_MEMWB(PC_plus4_MEMWB), .rd_MEMWB(rd_MEMWB),
    .mem2reg_MEMWB(mem2reg_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .memData_Out_MEM(memData_Out_MEM), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wb_ref(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] mem, input logic [31:0] pc4);
    case (sel)
      2'b00:   return alu;
      2'b01:   return mem;
      2'b10:   return pc4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_rdata_wb"}, read_data_MEMWB, 0);
    chk({tag, "_alu_wb"}, alu_result_MEMWB, 0);
    chk({tag, "_pc4_wb"}, PC_plus4_MEMWB, 0);
    chk({tag, "_rd_wb"}, rd_MEMWB, 0);
    chk({tag, "_m2r_wb"}, mem2reg_MEMWB, 0);
    chk({tag, "_rw_wb"}, RegWrite_MEMWB, 0);
    chk({tag, "_misalign"}, misalign_err, 0);
    chk({tag, "_buserr"}, bus_err, 0);
    chk({tag, "_wbout"}, memData_Out_MEM, 0);
  endtask

  // Entered and left just after a rising edge. ack_at is the BUSY cycle
  // (0 = first cycle after the request edge) in which dmem_ack pulses;
  // any value >= T means the memory never answers.
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] pc4, input logic [4:0] rd,
                           input logic rdn, input logic wrn, input logic [1:0] m2r,
                           input logic rw, input int ack_at, input logic [31:0] rdata);
    logic        access, aligned, acked;
    int          stalls, exp_stalls;
    logic [31:0] exp_rd;
    read_Address_EXMEM = addr;
    write_Data_EXMEM   = wdata;
    PC_plus4_EXMEM     = pc4;
    rd_EXMEM           = rd;
    memRead_EXMEM      = rdn;
    memWrite_EXMEM     = wrn;
    mem2reg_EXMEM      = m2r;
    RegWrite_EXMEM     = rw;
    dmem_ack           = 1'b0;
    dmem_rdata         = $urandom;
    #1;
    access  = rdn | wrn;
    aligned = (addr % 4) == 0;
    if (!(access && aligned)) begin
      chk("pass_stall", mem_stall, 0);
      chk("pass_req", dmem_req, 0);
      step();
      chk("pass_alu_wb", alu_result_MEMWB, addr);
      chk("pass_pc4_wb", PC_plus4_MEMWB, pc4);
      chk("pass_rd_wb", rd_MEMWB, rd);
      chk("pass_m2r_wb", mem2reg_MEMWB, m2r);
      chk("pass_rdata_wb", read_data_MEMWB, 0);
      chk("pass_rw_wb", RegWrite_MEMWB, access ? 1'b0 : rw);
      chk("pass_misalign", misalign_err, access);
      chk("pass_buserr", bus_err, 0);
      chk("pass_req_after", dmem_req, 0);
      chk("pass_wbout", memData_Out_MEM, wb_ref(m2r, addr, 32'd0, pc4));
      return;
    end
    stalls = mem_stall ? 1 : 0;
    acked  = 1'b0;
    for (int k = 0; k < T; k++) begin
      step();
      chk("busy_req", dmem_req, 1);
      chk("busy_we", dmem_we, wrn);
      chk("busy_addr", dmem_addr, addr);
      chk("busy_wdata", dmem_wdata, wdata);
      chk("busy_bubble_rw", RegWrite_MEMWB, 0);
      chk("busy_misalign", misalign_err, 0);
      chk("busy_buserr", bus_err, 0);
      if (k == ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        acked      = 1'b1;
      end
      #1;
      if (mem_stall) stalls++;
      if (acked) break;
    end
    exp_stalls = (ack_at < T) ? ack_at + 1 : T;
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    step();
    dmem_ack = 1'b0;
    exp_rd = (acked && !wrn) ? rdata : 32'd0;
    chk("done_req", dmem_req, 0);
    chk("done_rdata_wb", read_data_MEMWB, exp_rd);
    chk("done_alu_wb", alu_result_MEMWB, addr);
    chk("done_pc4_wb", PC_plus4_MEMWB, pc4);
    chk("done_rd_wb", rd_MEMWB, rd);
    chk("done_m2r_wb", mem2reg_MEMWB, m2r);
    chk("done_rw_wb", RegWrite_MEMWB, acked ? rw : 1'b0);
    chk("done_buserr", bus_err, !acked);
    chk("done_misalign", misalign_err, 0);
    chk("done_wbout", memData_Out_MEM, wb_ref(m2r, addr, exp_rd, pc4));
  endtask

  initial begin
    rst_n = 1'b0;
    read_Address_EXMEM = '0; write_Data_EXMEM = '0; PC_plus4_EXMEM = '0;
    rd_EXMEM = '0; memRead_EXMEM = 1'b0; memWrite_EXMEM = 1'b0;
    mem2reg_EXMEM = '0; RegWrite_EXMEM = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    step();
    step();
    chk_all_zero("reset");
    chk("reset_stall", mem_stall, 0);
    rst_n = 1'b1;

    // Directed cases
    run_instr(32'h1234, 32'h0, 32'h40, 5'd5, 1'b0, 1'b0, 2'b00, 1'b1, 0, 32'h0);
    run_instr(32'h100, 32'h0, 32'h44, 5'd7, 1'b1, 1'b0, 2'b01, 1'b1, 2, 32'hDEADBEEF);
    run_instr(32'h204, 32'hCAFEF00D, 32'h48, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 0, 32'h0);
    run_instr(32'h102, 32'h0, 32'h4C, 5'd9, 1'b1, 1'b0, 2'b01, 1'b1, 0, 32'h0);
    run_instr(32'h208, 32'h0, 32'h50, 5'd3, 1'b1, 1'b0, 2'b01, 1'b1, 100, 32'h0);
    run_instr(32'h20C, 32'h0, 32'h54, 5'd4, 1'b1, 1'b0, 2'b01, 1'b1, T - 1, 32'h55AA00FF);
    run_instr(32'h77, 32'h0, 32'h58, 5'd1, 1'b0, 1'b0, 2'b10, 1'b1, 0, 32'h0);
    run_instr(32'h78, 32'h0, 32'h5C, 5'd2, 1'b0, 1'b0, 2'b11, 1'b1, 0, 32'h0);

    // Reset during BUSY, then a stray ack in IDLE
    read_Address_EXMEM = 32'h300; memRead_EXMEM = 1'b1; mem2reg_EXMEM = 2'b01;
    RegWrite_EXMEM = 1'b1; rd_EXMEM = 5'd6; PC_plus4_EXMEM = 32'h60;
    step();
    step();
    chk("rst_busy_req", dmem_req, 1);
    rst_n = 1'b0;
    step();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    read_Address_EXMEM = '0; memRead_EXMEM = 1'b0; mem2reg_EXMEM = '0;
    RegWrite_EXMEM = 1'b0; rd_EXMEM = '0; PC_plus4_EXMEM = '0;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("late_ack_stall", mem_stall, 0);
    step();
    dmem_ack = 1'b0;
    chk_all_zero("late_ack");

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a    = $urandom;
      case (kind)
        0: run_instr(a, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0,
                     2'($urandom), 1'($urandom), 0, 32'h0);
        1: run_instr({a[31:2], 2'b00}, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0,
                     2'b01, 1'b1, $urandom_range(0, T + 1), $urandom);
        2: run_instr({a[31:2], 2'b00}, $urandom, $urandom, 5'($urandom), 1'b0, 1'b1,
                     2'b00, 1'b0, $urandom_range(0, T + 1), $urandom);
        default: run_instr({a[31:2], 2'($urandom_range(1, 3))}, $urandom, $urandom,
                           5'($urandom), 1'($urandom), 1'b1, 2'b01, 1'b1, 0, 32'h0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
